pc_unit: RTL

- Parametrised program counter and control-flow sequencer for the 8051 core.
- Handles increment, four jump modes, CALL/RET/RETI, and vectored interrupts with two priority levels.
- Pushes and pops the return address through the external byte-wide stack, one byte per cycle, under its own FSM.
- Sits between the instruction decoder and the stack/IRAM block; owns the only PC register.

---
 rtl/pc_pkg.sv | 26 ++
 rtl/pc_unit_irq_arbiter.sv | 47 ++++
 rtl/pc_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared state encoding, jump modes and default parameters for the PC sequencer.
package pc_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUSH_LO,
        ST_PUSH_HI,
        ST_POP_HI,
        ST_POP_LO,
        ST_POP_CAP,
        ST_VECTOR
    } state_e;

    localparam logic [1:0] JM_REL   = 2'd0;
    localparam logic [1:0] JM_ABS11 = 2'd1;
    localparam logic [1:0] JM_LONG  = 2'd2;
    localparam logic [1:0] JM_IND   = 2'd3;

    localparam int DEF_PC_W       = 16;
    localparam int DEF_N_IRQ      = 5;
    localparam int DEF_VEC_BASE   = 3;
    localparam int DEF_VEC_STRIDE = 8;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/pc_unit_irq_arbiter.sv
// irq_arbiter: two-level interrupt winner selection plus active-level tracking.
module irq_arbiter
    import pc_pkg::*;
#(
    parameter int N_IRQ = DEF_N_IRQ,
    parameter int IDX_W = idx_w(N_IRQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] pending,
    input  logic [N_IRQ-1:0] irq_hi,
    input  logic             accept,
    input  logic             accept_hi,
    input  logic             reti_done,
    output logic             valid,
    output logic [IDX_W-1:0] idx,
    output logic             level
);
    logic             act_lo_q, act_lo_d, act_hi_q, act_hi_d;
    logic [N_IRQ-1:0] hi_req, lo_req, sel;
    logic             use_hi, use_lo;

    always_comb begin
        hi_req = pending & irq_hi;
        lo_req = pending & ~irq_hi;
        use_hi = (|hi_req) && !act_hi_q;
        use_lo = (|lo_req) && !act_lo_q && !act_hi_q;
        sel    = use_hi ? hi_req : lo_req;
        valid  = use_hi || use_lo;
        level  = use_hi;
        idx    = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) idx = sel[i] ? IDX_W'(i) : idx;
        // reti releases the innermost (high) level first
        act_hi_d = (accept && accept_hi) ? 1'b1 : (reti_done && act_hi_q) ? 1'b0 : act_hi_q;
        act_lo_d = (accept && !accept_hi) ? 1'b1 : (reti_done && !act_hi_q) ? 1'b0 : act_lo_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_lo_q <= 1'b0;
            act_hi_q <= 1'b0;
        end else begin
            act_lo_q <= act_lo_d;
            act_hi_q <= act_hi_d;
        end
    end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter, jump/call/return sequencing and vectored interrupt entry.
module pc_unit
    import pc_pkg::*;
#(
    parameter int PC_W       = DEF_PC_W,
    parameter int N_IRQ      = DEF_N_IRQ,
    parameter int VEC_BASE   = DEF_VEC_BASE,
    parameter int VEC_STRIDE = DEF_VEC_STRIDE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             jmp,
    input  logic [1:0]       jmode,
    input  logic [7:0]       rel,
    input  logic [PC_W-1:0]  target,
    input  logic [7:0]       acc,
    input  logic [15:0]      dptr,
    input  logic             call,
    input  logic             ret,
    input  logic             reti,
    input  logic             instr_end,
    input  logic [N_IRQ-1:0] irq,
    input  logic [N_IRQ-1:0] irq_en,
    input  logic [N_IRQ-1:0] irq_hi,
    input  logic             ea,
    input  logic [7:0]       stk_rdata,
    output logic [7:0]       stk_wdata,
    output logic             stk_push,
    output logic             stk_pop,
    output logic [N_IRQ-1:0] irq_ack,
    output logic             busy,
    output logic [PC_W-1:0]  pc
);
    localparam int IDX_W = idx_w(N_IRQ);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d, tgt_q, tgt_d;
    logic [7:0]        hi_q, hi_d;
    logic              is_irq_q, is_irq_d, pop_reti_q, pop_reti_d, lvl_q, lvl_d;
    logic [IDX_W-1:0]  idx_q, idx_d, arb_idx;
    logic              arb_valid, arb_level, take;
    logic [PC_W-1:0]   jmp_pc, cmd_pc, vec_pc;

    irq_arbiter #(.N_IRQ(N_IRQ), .IDX_W(IDX_W)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .pending   (irq & irq_en),
        .irq_hi    (irq_hi),
        .accept    (state_q == ST_VECTOR && is_irq_q),
        .accept_hi (lvl_q),
        .reti_done (state_q == ST_POP_CAP && pop_reti_q),
        .valid     (arb_valid),
        .idx       (arb_idx),
        .level     (arb_level)
    );

    always_comb begin
        jmp_pc = (jmode == JM_REL)   ? pc_q + {{(PC_W-8){rel[7]}}, rel} :
                 (jmode == JM_ABS11) ? {pc_q[PC_W-1:11], target[10:0]} :
                 (jmode == JM_LONG)  ? target :
                                       PC_W'(dptr + {8'h0, acc});
        cmd_pc = jmp ? jmp_pc : inc ? pc_q + PC_W'(1) : pc_q;
        vec_pc = PC_W'(VEC_BASE + int'(idx_q) * VEC_STRIDE);
        take   = instr_end && ea && arb_valid;
        state_d    = state_q;
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        hi_d       = hi_q;
        is_irq_d   = is_irq_q;
        pop_reti_d = pop_reti_q;
        idx_d      = idx_q;
        lvl_d      = lvl_q;
        case (state_q)
            ST_IDLE: begin
                if (call) begin
                    tgt_d    = target;
                    is_irq_d = 1'b0;
                    state_d  = ST_PUSH_LO;
                end else if (ret || reti) begin
                    pop_reti_d = reti;
                    state_d    = ST_POP_HI;
                end else begin
                    // PC command lands first so the push saves the updated PC
                    pc_d = cmd_pc;
                    if (take) begin
                        is_irq_d = 1'b1;
                        idx_d    = arb_idx;
                        lvl_d    = arb_level;
                        state_d  = ST_PUSH_LO;
                    end
                end
            end
            ST_PUSH_LO: state_d = ST_PUSH_HI;
            ST_PUSH_HI: state_d = ST_VECTOR;
            ST_VECTOR: begin
                pc_d    = is_irq_q ? vec_pc : tgt_q;
                state_d = ST_IDLE;
            end
            ST_POP_HI: state_d = ST_POP_LO;
            ST_POP_LO: begin
                hi_d    = stk_rdata;
                state_d = ST_POP_CAP;
            end
            ST_POP_CAP: begin
                pc_d    = PC_W'({hi_q, stk_rdata});
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            tgt_q      <= '0;
            hi_q       <= '0;
            is_irq_q   <= 1'b0;
            pop_reti_q <= 1'b0;
            idx_q      <= '0;
            lvl_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tgt_q      <= tgt_d;
            hi_q       <= hi_d;
            is_irq_q   <= is_irq_d;
            pop_reti_q <= pop_reti_d;
            idx_q      <= idx_d;
            lvl_q      <= lvl_d;
        end
    end

    assign pc        = pc_q;
    assign busy      = state_q != ST_IDLE;
    assign stk_push  = state_q == ST_PUSH_LO || state_q == ST_PUSH_HI;
    assign stk_pop   = state_q == ST_POP_HI || state_q == ST_POP_LO;
    assign stk_wdata = (state_q == ST_PUSH_LO) ? pc_q[7:0] : (state_q == ST_PUSH_HI) ? 8'(pc_q >> 8) : 8'h0;
    assign irq_ack   = (state_q == ST_VECTOR && is_irq_q) ? N_IRQ'(1) << idx_q : '0;
endmodule
